// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha256_pkg
// Brief    : Shared SHA-256 types, round constants and message-schedule helpers
// Revision : 1.0 - initial release
// ============================================================================
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam word_t K_TABLE [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Word idx of a big-endian block; (15-idx)*32 is {~idx, 5'b0} for 4-bit idx
  function automatic word_t block_word(input logic [511:0] blk, input logic [3:0] idx);
    return blk[{~idx, 5'd0} +: 32];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_w_expand.sv
`default_nettype none
// ============================================================================
// Module   : sha256_w_expand
// Brief    : Combinational next-word expansion W[t+16] from the schedule window
// Revision : 1.0 - initial release
// ============================================================================
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w9,
  input  logic [31:0] w14,
  output logic [31:0] o_w_next
);

  assign o_w_next = small_sigma1(w14) + w9 + small_sigma0(w1) + w0;

endmodule
`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_schedule
// Brief    : Streams W[0..NUM_ROUNDS-1] with K[t] and t from one 512-bit block
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_i,
  input  logic         flush_i,
  output logic         w_valid_o,
  input  logic         w_ready_i,
  output logic [31:0]  w_o,
  output logic [31:0]  k_o,
  output logic [5:0]   t_o,
  output logic         last_o
);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;
  localparam logic [5:0] c_LAST = 6'(NUM_ROUNDS - 1);

  logic [0:0] r_state;
  logic [0:0] w_state_next;
  logic [5:0] r_t;
  word_t      r_window [0:15];
  word_t      w_expand;
  logic       w_at_last;
  logic       w_accept;
  logic       w_fire;

  assign w_at_last = (r_t == c_LAST);
  assign w_accept  = blk_valid_i & blk_ready_o;
  assign w_fire    = w_valid_o & w_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = c_IDLE;
    end else if (w_accept) begin
      w_state_next = c_RUN;
    end else if (w_fire && w_at_last) begin
      w_state_next = c_IDLE;
    end
  end

  // blk_ready_o also opens on the last-word handshake for zero-bubble chaining
  always_comb begin
    w_valid_o   = 1'b0;
    last_o      = 1'b0;
    blk_ready_o = 1'b0;
    case (r_state)
      c_IDLE: begin
        blk_ready_o = ~flush_i;
      end
      c_RUN: begin
        w_valid_o   = 1'b1;
        last_o      = w_at_last;
        blk_ready_o = ~flush_i & w_at_last & w_ready_i;
      end
      default: begin
        w_valid_o = 1'b0;
      end
    endcase
  end

  sha256_w_expand u_expand (
    .w0       (r_window[0]),
    .w1       (r_window[1]),
    .w9       (r_window[9]),
    .w14      (r_window[14]),
    .o_w_next (w_expand)
  );

  // Window invariant: r_window[i] == W[r_t + i]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t <= '0;
      for (int i = 0; i < 16; i++) begin
        r_window[i] <= '0;
      end
    end else if (flush_i) begin
      r_t <= '0;
    end else if (w_accept) begin
      r_t <= '0;
      for (int i = 0; i < 16; i++) begin
        r_window[i] <= block_word(blk_i, 4'(i));
      end
    end else if (w_fire) begin
      r_t <= w_at_last ? 6'd0 : r_t + 6'd1;
      for (int i = 0; i < 15; i++) begin
        r_window[i] <= r_window[i + 1];
      end
      r_window[15] <= w_expand;
    end
  end

  assign w_o = r_window[0];
  assign k_o = K_TABLE[r_t];
  assign t_o = r_t;

endmodule
`default_nettype wire
